// File: rtl/snes_pkg.sv
`default_nettype none
// ============================================================================
// snes_pkg : button indices, poll FSM states, screen defaults, clamp helper
// Revision : 1.0
// ============================================================================
package snes_pkg;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LATCH  = 2'd1,
        SHIFT  = 2'd2,
        UPDATE = 2'd3
    } snes_state_t;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    // Saturate a signed 11-bit coordinate into [0, max_v].
    function automatic logic [9:0] clamp_pos(input logic signed [10:0] v,
                                             input logic [9:0] max_v);
        if (v[10])
            return 10'd0;
        else if (v > $signed({1'b0, max_v}))
            return max_v;
        else
            return v[9:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/snes_pad_reader.sv
`default_nettype none
// ============================================================================
// snes_pad_reader : tick divider, latch/shift sequencing, 16-bit pad capture
// Revision        : 1.0
// ============================================================================
module snes_pad_reader
    import snes_pkg::*;
#(
    parameter int CLK_DIV = 300
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        snes_data,
    output logic        snes_latch,
    output logic        snes_clk,
    output logic        busy,
    output logic [15:0] raw,
    output logic        raw_valid
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    snes_state_t   state;
    logic [DW-1:0] div_cnt;
    logic [3:0]    bit_idx;
    logic          phase;
    logic          tick_end;

    assign tick_end = (div_cnt == DW'(CLK_DIV - 1));

    // phase counts the two latch ticks in LATCH, and high/low half-bit in SHIFT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_idx    <= 4'd0;
            phase      <= 1'b0;
            raw        <= 16'd0;
            raw_valid  <= 1'b0;
            snes_latch <= 1'b0;
            snes_clk   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            raw_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state      <= LATCH;
                        div_cnt    <= '0;
                        phase      <= 1'b0;
                        snes_latch <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LATCH: begin
                    if (tick_end) begin
                        div_cnt <= '0;
                        if (phase) begin
                            state      <= SHIFT;
                            bit_idx    <= 4'd0;
                            phase      <= 1'b0;
                            snes_latch <= 1'b0;
                            snes_clk   <= 1'b1;
                        end else begin
                            phase <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                SHIFT: begin
                    if (tick_end) begin
                        div_cnt <= '0;
                        if (!phase) begin
                            raw[bit_idx] <= snes_data;
                            phase        <= 1'b1;
                            snes_clk     <= 1'b0;
                        end else begin
                            phase    <= 1'b0;
                            snes_clk <= 1'b1;
                            if (bit_idx == 4'd15) begin
                                state     <= UPDATE;
                                raw_valid <= 1'b1;
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_move_controller.sv
`default_nettype none
// ============================================================================
// sprite_move_controller : per-frame SNES pad poll and clamped sprite movement
// Revision               : 1.0
// ============================================================================
module sprite_move_controller
    import snes_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int STEP     = 4,
    parameter int CLK_DIV  = 300
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        snes_data,
    output logic        snes_latch,
    output logic        snes_clk,
    output logic [11:0] buttons,
    output logic        pad_present,
    output logic [9:0]  col_out,
    output logic [9:0]  row_out,
    output logic        busy
);

    localparam logic [9:0]        COL_MAX    = 10'(SCREEN_W - SPRITE_W);
    localparam logic [9:0]        ROW_MAX    = 10'(SCREEN_H - SPRITE_H);
    localparam logic [9:0]        COL_CENTER = 10'((SCREEN_W - SPRITE_W) / 2);
    localparam logic [9:0]        ROW_CENTER = 10'((SCREEN_H - SPRITE_H) / 2);
    localparam logic signed [10:0] STEP_S    = 11'(STEP);

    logic [15:0]        raw;
    logic               raw_valid;
    logic [11:0]        btn_n;
    logic               present_n;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic [9:0]         col_next;
    logic [9:0]         row_next;

    snes_pad_reader #(
        .CLK_DIV (CLK_DIV)
    ) u_reader (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .snes_data   (snes_data),
        .snes_latch  (snes_latch),
        .snes_clk    (snes_clk),
        .busy        (busy),
        .raw         (raw),
        .raw_valid   (raw_valid)
    );

    // Opposing directions on one axis cancel; each axis moves independently.
    always_comb begin
        btn_n     = ~raw[11:0];
        present_n = (raw[15:12] == 4'b1111);
        dx        = 11'sd0;
        dy        = 11'sd0;
        if (btn_n[BTN_UP] && !btn_n[BTN_DOWN])
            dy = -STEP_S;
        else if (btn_n[BTN_DOWN] && !btn_n[BTN_UP])
            dy = STEP_S;
        if (btn_n[BTN_LEFT] && !btn_n[BTN_RIGHT])
            dx = -STEP_S;
        else if (btn_n[BTN_RIGHT] && !btn_n[BTN_LEFT])
            dx = STEP_S;
        col_next = clamp_pos($signed({1'b0, col_out}) + dx, COL_MAX);
        row_next = clamp_pos($signed({1'b0, row_out}) + dy, ROW_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buttons     <= 12'd0;
            pad_present <= 1'b0;
            col_out     <= COL_CENTER;
            row_out     <= ROW_CENTER;
        end else if (raw_valid) begin
            pad_present <= present_n;
            if (!present_n) begin
                buttons <= 12'd0;
            end else begin
                buttons <= btn_n;
                if (btn_n[BTN_START]) begin
                    col_out <= COL_CENTER;
                    row_out <= ROW_CENTER;
                end else begin
                    col_out <= col_next;
                    row_out <= row_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_move_controller.sv
`default_nettype none
// ============================================================================
// tb_sprite_move_controller : scoreboard bench with SNES pad model
// Revision                  : 1.0
// ============================================================================
module tb_sprite_move_controller;

    localparam int CLK_DIV = 2;
    localparam int STEP    = 4;
    localparam int CX      = 312;
    localparam int CY      = 232;
    localparam int COL_MAX = 624;
    localparam int ROW_MAX = 464;

    typedef struct packed {
        logic [11:0] btn;
        logic        pres;
        logic [9:0]  col;
        logic [9:0]  row;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [15:0] pad_raw = 16'hFFFF;
    int          pad_idx = 0;
    logic        snes_data;
    logic        snes_latch;
    logic        snes_clk;
    logic [11:0] buttons;
    logic        pad_present;
    logic [9:0]  col_out;
    logic [9:0]  row_out;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   mcol = CX;
    int   mrow = CY;

    sprite_move_controller #(
        .SPRITE_W (16),
        .SPRITE_H (16),
        .SCREEN_W (640),
        .SCREEN_H (480),
        .STEP     (STEP),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .snes_data   (snes_data),
        .snes_latch  (snes_latch),
        .snes_clk    (snes_clk),
        .buttons     (buttons),
        .pad_present (pad_present),
        .col_out     (col_out),
        .row_out     (row_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Pad: latch loads bit 0, each rising pad clock advances to the next bit.
    always @(posedge snes_latch or posedge snes_clk) begin
        if (snes_latch)
            pad_idx = 0;
        else if (pad_idx < 16)
            pad_idx = pad_idx + 1;
    end
    assign snes_data = (pad_idx < 16) ? pad_raw[pad_idx[3:0]] : 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_poll(input logic [15:0] raw);
        exp_t        e;
        logic [11:0] b;
        int          dx;
        int          dy;
        if (raw[15:12] != 4'hF) begin
            e.btn  = 12'd0;
            e.pres = 1'b0;
        end else begin
            b      = ~raw[11:0];
            e.btn  = b;
            e.pres = 1'b1;
            if (b[3]) begin
                mcol = CX;
                mrow = CY;
            end else begin
                dy   = (b[5] ? STEP : 0) - (b[4] ? STEP : 0);
                dx   = (b[7] ? STEP : 0) - (b[6] ? STEP : 0);
                mrow = mrow + dy;
                mcol = mcol + dx;
                if (mrow < 0) mrow = 0;
                if (mrow > ROW_MAX) mrow = ROW_MAX;
                if (mcol < 0) mcol = 0;
                if (mcol > COL_MAX) mcol = COL_MAX;
            end
        end
        e.col = 10'(mcol);
        e.row = 10'(mrow);
        q.push_back(e);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_col"}, col_out, CX);
        chk({tag, "_row"}, row_out, CY);
        chk({tag, "_sclk"}, snes_clk, 1);
        chk({tag, "_latch"}, snes_latch, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_buttons"}, buttons, 0);
        chk({tag, "_present"}, pad_present, 0);
    endtask

    // One poll; extra_at pulses frame_start mid-poll, reset_at aborts the poll.
    task automatic poll(input logic [15:0] raw, input int extra_at, input int reset_at);
        int c;
        bit done;
        pad_raw = raw;
        @(posedge clk); #1;
        frame_start = 1'b1;
        model_poll(raw);
        @(posedge clk); #1;
        frame_start = 1'b0;
        c    = 1;
        done = 1'b0;
        while (!done) begin
            if (c == reset_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                void'(q.pop_back());
                mcol = CX;
                mrow = CY;
                chk_reset_values("midpoll_reset");
                @(negedge clk); #1;
                reset = 1'b0;
                done  = 1'b1;
            end else begin
                frame_start = (c == extra_at);
                @(posedge clk); #1;
                frame_start = 1'b0;
                c++;
                if (!busy) begin
                    done = 1'b1;
                end else if (c > 200) begin
                    chk("poll_timeout", c, 34 * CLK_DIV + 1);
                    done = 1'b1;
                end
            end
        end
        repeat (2) @(posedge clk);
    endtask

    // Monitor: every completed poll pops one expectation and checks timing.
    int   busy_cyc = 0;
    int   lat_cyc = 0;
    int   low_cyc = 0;
    int   falls = 0;
    logic prev_busy = 1'b0;
    logic prev_sclk = 1'b1;
    exp_t got;

    always @(negedge clk) begin
        if (reset) begin
            busy_cyc  = 0;
            lat_cyc   = 0;
            low_cyc   = 0;
            falls     = 0;
            prev_busy = 1'b0;
            prev_sclk = 1'b1;
        end else begin
            if (busy) busy_cyc++;
            if (snes_latch) lat_cyc++;
            if (!snes_clk) low_cyc++;
            if (prev_sclk && !snes_clk) falls++;
            if (prev_busy && !busy) begin
                if (q.size() == 0) begin
                    chk("unexpected_update", 1, 0);
                end else begin
                    got = q.pop_front();
                    chk("buttons", buttons, got.btn);
                    chk("pad_present", pad_present, got.pres);
                    chk("col_out", col_out, got.col);
                    chk("row_out", row_out, got.row);
                    chk("busy_cycles", busy_cyc, 34 * CLK_DIV + 1);
                    chk("latch_cycles", lat_cyc, 2 * CLK_DIV);
                    chk("sclk_low_cycles", low_cyc, 16 * CLK_DIV);
                    chk("sclk_pulses", falls, 16);
                end
                busy_cyc = 0;
                lat_cyc  = 0;
                low_cyc  = 0;
                falls    = 0;
            end
            prev_busy = busy;
            prev_sclk = snes_clk;
        end
    end

    initial begin
        logic [15:0] r;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk_reset_values("idle");

        poll(16'hFF7F, 0, 0);
        repeat (60) poll(16'hFFEF, 0, 0);
        repeat (76) poll(16'hFF7F, 0, 0);
        repeat (70) poll(16'hFF1F, 0, 0);
        repeat (160) poll(16'hFFBF, 0, 0);
        poll(16'hFFF7, 0, 0);
        poll(16'h0FFF, 0, 0);
        poll(16'hFFDF, 10, 0);
        poll(16'hFF7F, 0, 40);
        poll(16'hFF7F, 0, 0);

        for (int i = 0; i < 150; i++) begin
            r = 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                r[15:12] = 4'hF;
                if ($urandom_range(0, 4) != 0) r[3] = 1'b1;
            end
            poll(r, 0, 0);
        end

        repeat (10) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
